// File: rtl/exc_flush_ctrl.sv
// Exception/ERTN sequencer between writeback and the CSR file: prioritises the
// committing instruction's exceptions and pending interrupts, then redirects fetch.
module exc_flush_ctrl #(
  parameter int FLUSH_MIN = 2,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ws_valid,
  input  logic [PC_W-1:0] ws_pc,
  input  logic [4:0]      ws_ex_vec,
  input  logic            ws_ertn,
  input  logic            crmd_ie,
  input  logic [12:0]     estat_is,
  input  logic [12:0]     ecfg_lie,
  input  logic [PC_W-1:0] eentry,
  input  logic [PC_W-1:0] era,
  input  logic            fetch_ack,
  output logic            wb_ex,
  output logic [5:0]      wb_ecode,
  output logic [8:0]      wb_esubcode,
  output logic [PC_W-1:0] wb_pc,
  output logic            eret_flush,
  output logic            flush_req,
  output logic [PC_W-1:0] flush_target,
  output logic            commit_block
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_WAIT_ACK
  } state_t;

  localparam logic [3:0] LP_HOLD_INIT = 4'(FLUSH_MIN - 1);

  state_t          r_state;
  logic [3:0]      r_hold_cnt;
  logic            r_int_pend;
  logic            r_flush_req;
  logic            r_commit_block;
  logic [PC_W-1:0] r_flush_target;

  logic            w_take;
  logic            w_exc;
  logic            w_ertn_commit;
  logic [5:0]      w_ecode;

  // Interrupt outranks every synchronous exception; then ADEF, INE, SYS, BRK, ALE.
  function automatic logic [5:0] f_ecode(input logic int_pend, input logic [4:0] ex);
    logic [5:0] code;
    if (int_pend)   code = 6'h00;
    else if (ex[0]) code = 6'h08;
    else if (ex[1]) code = 6'h0D;
    else if (ex[2]) code = 6'h0B;
    else if (ex[3]) code = 6'h0C;
    else if (ex[4]) code = 6'h09;
    else            code = 6'h00;
    return code;
  endfunction

  assign w_take        = ws_valid & ~r_commit_block;
  assign w_exc         = w_take & (r_int_pend | (|ws_ex_vec));
  assign w_ertn_commit = w_take & ws_ertn & ~w_exc;
  assign w_ecode       = f_ecode(r_int_pend, ws_ex_vec);

  assign wb_ex        = w_exc;
  assign wb_ecode     = w_exc ? w_ecode : 6'h00;
  assign wb_esubcode  = 9'd0;
  assign wb_pc        = w_exc ? ws_pc : '0;
  assign eret_flush   = w_ertn_commit;
  assign flush_req    = r_flush_req;
  assign commit_block = r_commit_block;
  assign flush_target = r_flush_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hold_cnt     <= 4'd0;
      r_int_pend     <= 1'b0;
      r_flush_req    <= 1'b0;
      r_commit_block <= 1'b0;
      r_flush_target <= '0;
    end else begin
      r_int_pend <= (|(estat_is & ecfg_lie)) & crmd_ie;
      case (r_state)
        S_IDLE: begin
          if (w_exc || w_ertn_commit) begin
            r_state        <= S_FLUSH;
            r_hold_cnt     <= LP_HOLD_INIT;
            r_flush_req    <= 1'b1;
            r_commit_block <= 1'b1;
            r_flush_target <= w_exc ? eentry : era;
          end
        end
        S_FLUSH: begin
          // An acknowledge arriving before the minimum hold has elapsed is dropped.
          if (r_hold_cnt != 4'd0) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end else if (fetch_ack) begin
            r_state        <= S_IDLE;
            r_flush_req    <= 1'b0;
            r_commit_block <= 1'b0;
          end else begin
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (fetch_ack) begin
            r_state        <= S_IDLE;
            r_flush_req    <= 1'b0;
            r_commit_block <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_flush_req    <= 1'b0;
          r_commit_block <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Exception/ERTN sequencer between the writeback stage and the CSR file.
- Each cycle it prioritises the committing instruction's exception flags plus a pending interrupt, and emits the single-cycle CSR side-effect strobes (wb_ex/ecode/esubcode/pc, eret_flush).
- It then runs a pipeline-flush handshake that redirects fetch to EENTRY or ERA and blocks further commits until fetch acknowledges.

Parameters:
- FLUSH_MIN, 2, minimum cycles flush_req stays high before fetch_ack is honoured (1..15).
- PC_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ws_valid  in  1  writeback instruction valid this cycle
- ws_pc  in  PC_W  writeback instruction PC
- ws_ex_vec  in  5  exception flags {ALE, BRK, SYS, INE, ADEF}, bit0=ADEF
- ws_ertn  in  1  writeback instruction is ERTN
- crmd_ie  in  1  CSR CRMD.IE
- estat_is  in  13  CSR ESTAT.IS
- ecfg_lie  in  13  CSR ECFG.LIE
- eentry  in  PC_W  exception entry address
- era  in  PC_W  exception return address
- fetch_ack  in  1  fetch stage has taken the redirect
- wb_ex  out  1  exception commit strobe to CSR
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  PC_W  faulting PC to ERA
- eret_flush  out  1  ERTN commit strobe to CSR
- flush_req  out  1  pipeline flush / fetch redirect request
- flush_target  out  PC_W  redirect address
- commit_block  out  1  writeback must not commit (high while flushing)

Behaviour:
- Reset (async): state=IDLE, int_pend=0, hold counter=0. All outputs 0, including flush_target=0.
- int_pend register, updated every cycle: (|(estat_is & ecfg_lie)) & crmd_ie. So an interrupt is seen one cycle after it is raised.
- take = ws_valid & ~commit_block.
- Priority, highest first, evaluated only when take=1:
  - int_pend: ecode 0x00, sub 0
  - ADEF: ecode 0x08, sub 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
  - Subcode is 0 for all except as listed.
- Exception commit (take & (int_pend | |ws_ex_vec)), combinational in the same cycle:
  - wb_ex=1, wb_ecode/wb_esubcode per priority, wb_pc=ws_pc.
  - Next state FLUSH; flush_target latched to eentry.
- ERTN commit (take & ws_ertn & no exception):
  - eret_flush=1 for one cycle; flush_target latched to era; next state FLUSH.
- Exception together with ws_ertn: exception wins, eret_flush=0.
- wb_ex and eret_flush are 1-cycle pulses and never high together.
- wb_ecode/wb_esubcode/wb_pc are 0 when wb_ex=0.
- States:
  - IDLE: commit_block=0, flush_req=0. Moves to FLUSH on a commit as above.
  - FLUSH: flush_req=1, commit_block=1, counter loads FLUSH_MIN-1 on entry and decrements. At 0, go to WAIT_ACK, or straight to IDLE if fetch_ack=1 in that cycle.
  - WAIT_ACK: flush_req=1, commit_block=1. fetch_ack=1 returns to IDLE the next cycle. No timeout; holds indefinitely.
  - fetch_ack seen while counter is nonzero is ignored.
- flush_target is stable for the whole FLUSH/WAIT_ACK period and retains its value in IDLE.
- int_pend keeps tracking during a flush. The first valid instruction in IDLE with int_pend=1 takes INT.
- Asynchronous reset mid-flush returns to IDLE immediately; all outputs drop without waiting for clk.
- ws_valid is ignored whenever commit_block=1. Those instructions are squashed by the pipeline.

Test Plan:
- Reset asserted mid-WAIT_ACK, between clock edges -> flush_req, commit_block and flush_target go to 0 immediately; state IDLE.
- ws_valid=1, ws_ex_vec=5'b00100 (SYS), ws_pc=0x1C000100, eentry=0x1C008000 -> same cycle wb_ex=1, ecode=0x0B, wb_pc=0x1C000100. Next 2 cycles flush_req=1, flush_target=0x1C008000. fetch_ack on cycle 3 -> IDLE on cycle 4.
- ws_ex_vec=5'b10011 (ADEF+INE+ALE) -> ecode=0x08, sub=0. Also raise estat_is[11]=1, ecfg_lie[11]=1, crmd_ie=1 one cycle earlier -> ecode=0x00 instead.
- ws_ertn=1, era=0x1C000204, no exception -> eret_flush=1 for exactly one cycle, wb_ex=0, flush_target=0x1C000204. With ws_ex_vec=BRK in the same cycle -> wb_ex=1, ecode=0x0C, eret_flush=0.
- During WAIT_ACK: ws_valid=1 with SYS, and fetch_ack=1 pulsed during FLUSH counting -> no wb_ex; early ack ignored; flush stays until a later ack.
- crmd_ie=0 with estat_is&ecfg_lie nonzero -> no INT taken. Set crmd_ie=1 -> INT on the second valid instruction cycle after the change.
